// File: rtl/pipe_adder_pkg.sv
// Shared constants, stage-count helper and stage-register layout for pipe_adder.
package pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;
  // Upper bound on WIDTH; stage registers are sized to this and trimmed by use.
  localparam int unsigned MAX_WIDTH = 64;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 carry;
    logic                 cmsb;
  } stage_t;

  function automatic int unsigned stages_f(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; slave is the adder side.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ou;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, in0, in1, cin, sub, out_ready,
    input  in_ready, out_valid, ou, cout, ovf, zero
  );

  modport slave (
    input  in_valid, in0, in1, cin, sub, out_ready,
    output in_ready, out_valid, ou, cout, ovf, zero
  );

endinterface

// File: rtl/pipe_adder_chunk.sv
// Combinational CHUNK-bit ripple slice (adder_chunk) built from Full_adder cells;
// also exposes the carry into the slice MSB for overflow detection.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    Full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor, one CHUNK-bit carry slice per registered stage.
// Define PIPE_ADDER_FLAGS_EN to build the ovf/zero flag logic.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic          clk,
  input  logic          reset,
  pipe_adder_if.slave   bus
);

  localparam int unsigned STAGES = stages_f(WIDTH, CHUNK);
  localparam int unsigned LAST   = STAGES - 1;

  if (((WIDTH % CHUNK) != 0) || (WIDTH > MAX_WIDTH)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of CHUNK and not exceed MAX_WIDTH");
  end

  stage_t           st  [STAGES];
  stage_t           src [STAGES];
  stage_t           nxt [STAGES];
  logic [CHUNK-1:0] s_sl [STAGES];
  logic             co   [STAGES];
  logic             cm   [STAGES];
  logic             advance;
  logic [WIDTH-1:0] res;

  // Stage 0 sees the raw operands with B already conditioned for subtract;
  // later stages see the previous register, carrying skewed operand slices.
  always_comb begin
    src[0]       = '0;
    src[0].valid = bus.in_valid;
    src[0].a     = MAX_WIDTH'(bus.in0);
    src[0].b     = bus.sub ? MAX_WIDTH'(~bus.in1) : MAX_WIDTH'(bus.in1);
    src[0].carry = bus.sub | bus.cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = st[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (src[k].a[k*CHUNK +: CHUNK]),
      .b    (src[k].b[k*CHUNK +: CHUNK]),
      .ci   (src[k].carry),
      .s    (s_sl[k]),
      .co   (co[k]),
      .cmsb (cm[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt[k]                       = src[k];
      nxt[k].sum[k*CHUNK +: CHUNK] = s_sl[k];
      nxt[k].carry                 = co[k];
`ifdef PIPE_ADDER_FLAGS_EN
      nxt[k].cmsb                  = cm[k];
`else
      nxt[k].cmsb                  = 1'b0;
`endif
    end
  end

  assign advance = bus.out_ready | ~st[LAST].valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st[k] <= nxt[k];
      end
    end
  end

  assign res           = st[LAST].sum[WIDTH-1:0];
  assign bus.in_ready  = advance;
  assign bus.out_valid = st[LAST].valid;
  assign bus.ou        = res;
  assign bus.cout      = st[LAST].carry;

`ifdef PIPE_ADDER_FLAGS_EN
  assign bus.ovf  = st[LAST].carry ^ st[LAST].cmsb;
  // Gated by valid so the all-zero reset state does not report zero.
  assign bus.zero = st[LAST].valid & (res == '0);
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif

endmodule
